// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: architectural register indices,
// default widths and the reset values of $sp and $gp.
package mips_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_GP   = 28;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [31:0] SP_INIT_DEF = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_INIT_DEF = 32'h1000_8000;

endpackage

// File: rtl/reg_read_port.sv
// Combinational register-file read mux: index 0 reads as zero, with optional
// same-cycle forwarding of the pending write when BYPASS is set.
module reg_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter bit BYPASS = 1'b0
) (
    input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                addr,
    input  logic                             fwd_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    output logic [DATA_W-1:0]                data
);

    logic addr_nonzero;

    assign addr_nonzero = (addr != ADDR_W'(REG_ZERO));

    always_comb begin
        data = '0;
        if (addr_nonzero) begin
            data = regs[addr];
        end
        // The write path already gates fwd_en on reset, so a match here is always live.
        if (BYPASS && fwd_en && addr_nonzero && (wr_addr == addr)) begin
            data = wr_data;
        end
    end

endmodule

// File: rtl/reg_file_32.sv
// 32 x 32 MIPS general-purpose register file with $0 hardwired to zero.
// Define REG_BYPASS_EN to forward the pending write onto read ports A and B.
module reg_file_32
    import mips_pkg::*;
#(
    parameter int                 DATA_W  = DATA_W_DEF,
    parameter int                 ADDR_W  = ADDR_W_DEF,
    parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(SP_INIT_DEF),
    parameter logic [DATA_W-1:0]  GP_INIT = DATA_W'(GP_INIT_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREGS = 2**ADDR_W;

`ifdef REG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Entry 0 has no storage; the view below supplies its constant zero.
    logic [DATA_W-1:0]              mem [1:NREGS-1];
    logic [NREGS-1:0][DATA_W-1:0]   regs;
    logic                           wr_live;

    assign wr_live = rst_n && wr_en && (wr_addr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                if (i == REG_SP) begin
                    mem[i] <= SP_INIT;
                end else if (i == REG_GP) begin
                    mem[i] <= GP_INIT;
                end else begin
                    mem[i] <= '0;
                end
            end
        end else if (wr_live) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        regs[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            regs[i] = mem[i];
        end
    end

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_a (
        .regs    (regs),
        .addr    (rd_addr_a),
        .fwd_en  (wr_live),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (rd_data_a)
    );

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_b (
        .regs    (regs),
        .addr    (rd_addr_b),
        .fwd_en  (wr_live),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (rd_data_b)
    );

    // The debug port always shows the committed contents.
    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_port_dbg (
        .regs    (regs),
        .addr    (dbg_addr),
        .fwd_en  (1'b0),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (dbg_data)
    );

endmodule

// File: tb/tb_reg_file_32.sv
// Bench for reg_file_32: directed scenarios followed by random traffic,
// all checked against an array-based reference model of the register file.
module tb_reg_file_32;

    localparam logic [31:0] SP_RST = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_RST = 32'h1000_8000;

`ifdef REG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, dbg_addr;
    logic [31:0] rd_data_a, rd_data_b, wr_data, dbg_data;
    logic        wr_en;

    logic [31:0] model [32];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_file_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    function automatic logic [31:0] rst_val(input int idx);
        if (idx == 29) return SP_RST;
        if (idx == 28) return GP_RST;
        return 32'h0;
    endfunction

    // What a read port should show right now, given the model and the pending inputs.
    function automatic logic [31:0] expect_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && rst_n && wr_en && wr_addr == a) return wr_data;
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; the model commits what the DUT saw, then outputs settle.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = rst_val(i);
        end else if (wr_en && wr_addr != 5'd0) begin
            model[wr_addr] = wr_data;
        end
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; dbg_addr = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset for two edges, then sweep every index through the debug port.
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check($sformatf("reset_reg%0d", i), dbg_data, rst_val(i));
        end

        // Write then read on both ports; ALU add of the two operands.
        write_reg(5'd8, 32'hDEAD_BEEF);
        write_reg(5'd9, 32'h0000_0005);
        rd_addr_a = 5'd8; rd_addr_b = 5'd9;
        #1;
        check("wr_rd_a", rd_data_a, 32'hDEAD_BEEF);
        check("wr_rd_b", rd_data_b, 32'h0000_0005);
        check("alu_add", rd_data_a + rd_data_b, 32'hDEAD_BEF4);
        rd_addr_b = 5'd8;
        #1;
        check("same_addr_ab", rd_data_b, rd_data_a);

        // $0 must swallow writes.
        write_reg(5'd0, 32'hFFFF_FFFF);
        rd_addr_a = 5'd0;
        #1;
        check("zero_after_wr", rd_data_a, 32'h0);
        step();
        check("zero_later", rd_data_a, 32'h0);

        // wr_en low must leave the target untouched.
        write_reg(5'd10, 32'h1234_5678);
        wr_en = 1'b0; wr_addr = 5'd10; wr_data = 32'h0;
        step(); step(); step();
        dbg_addr = 5'd10;
        #1;
        check("wr_en_gate", dbg_data, 32'h1234_5678);

        // Same-cycle read and write of one index.
        write_reg(5'd11, 32'h0000_000A);
        rd_addr_a = 5'd11;
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h0000_000B;
        #1;
        check("rw_same_cycle", rd_data_a, BYP ? 32'h0000_000B : 32'h0000_000A);
        dbg_addr = 5'd11;
        #1;
        check("rw_dbg_no_byp", dbg_data, 32'h0000_000A);
        step();
        wr_en = 1'b0;
        #1;
        check("rw_after_edge", rd_data_a, 32'h0000_000B);

        // Mid-run reset discards the write presented with it.
        write_reg(5'd29, 32'h0);
        write_reg(5'd5, 32'h0000_0007);
        dbg_addr = 5'd29;
        #1;
        check("sp_overwritten", dbg_data, 32'h0);
        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_0009;
        rd_addr_a = 5'd5;
        #1;
        check("no_byp_in_reset", rd_data_a, 32'h0000_0007);
        step();
        rst_n = 1'b1; wr_en = 1'b0;
        #1;
        check("midrst_sp", dbg_data, SP_RST);
        dbg_addr = 5'd5;
        #1;
        check("midrst_r5", dbg_data, 32'h0);
        check("midrst_r5_a", rd_data_a, 32'h0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(24) != 0);
            wr_en     = $urandom_range(1) != 0;
            wr_addr   = 5'($urandom_range(31));
            wr_data   = $urandom;
            rd_addr_a = ($urandom_range(3) == 0) ? wr_addr : 5'($urandom_range(31));
            rd_addr_b = ($urandom_range(3) == 0) ? wr_addr : 5'($urandom_range(31));
            dbg_addr  = ($urandom_range(3) == 0) ? wr_addr : 5'($urandom_range(31));
            #1;
            check("rand_a", rd_data_a, expect_read(rd_addr_a, BYP));
            check("rand_b", rd_data_b, expect_read(rd_addr_b, BYP));
            check("rand_dbg", dbg_data, expect_read(dbg_addr, 1'b0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
